// File: rtl/palindrome_detect.sv
`default_nettype none
// ============================================================================
// Module   : palindrome_detect
// Brief    : Streaming serial-bit palindrome detector over a LEN-bit sliding
//            window, with valid gating, sync clear, fill tracking and a
//            saturating hit counter.
// Revision : 1.0 - initial release
// ============================================================================
module palindrome_detect #(
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             clear_i,
    input  logic             x_i,
    output logic             palindrome_o,
    output logic             window_full_o,
    output logic [CNT_W-1:0] hit_cnt_o
);

    localparam int                  c_fill_w   = $clog2(LEN);
    localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(LEN - 1);

    logic [LEN-2:0]     r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic [CNT_W-1:0]   r_hit;

    logic [LEN-1:0]     w_win;
    logic [LEN/2-1:0]   w_eq;
    logic               w_pal;
    logic               w_accept;
    logic [LEN-2:0]     w_hist_next;

    // w_win[0] is the current bit, w_win[k] the k-th most recent history bit
    assign w_win = {r_hist, x_i};

    for (genvar k = 0; k < LEN / 2; k++) begin : g_cmp
        assign w_eq[k] = (w_win[k] == w_win[LEN-1-k]);
    end

    assign w_pal    = &w_eq;
    assign w_accept = valid_i & ~clear_i;

    if (LEN == 2) begin : g_hist_len2
        assign w_hist_next = x_i;
    end else begin : g_hist_shift
        assign w_hist_next = {r_hist[LEN-3:0], x_i};
    end

    assign window_full_o = (r_fill == c_fill_max);
    assign palindrome_o  = w_accept & window_full_o & w_pal;
    assign hit_cnt_o     = r_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_hit  <= '0;
        end else if (clear_i) begin
            r_hist <= '0;
            r_fill <= '0;
            r_hit  <= '0;
        end else if (valid_i) begin
            r_hist <= w_hist_next;
            if (!window_full_o) begin
                r_fill <= r_fill + c_fill_w'(1);
            end
            // Saturate rather than wrap so a stuck-high count stays visible
            if (palindrome_o && !(&r_hit)) begin
                r_hit <= r_hit + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palindrome_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_palindrome_detect
// Brief    : Self-checking bench for palindrome_detect across four parameter
//            sets, with a queue-based reference model and directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_palindrome_detect;

    typedef bit bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       v [4];
    logic       c [4];
    logic       x [4];
    logic       p [4];
    logic       f [4];
    logic [7:0] hc [4];
    logic [7:0] hc0, hc1, hc3;
    logic [1:0] hc2;

    int         checks = 0;
    int         errors = 0;

    localparam int c_len [4] = '{3, 4, 3, 5};
    localparam int c_max [4] = '{255, 255, 3, 255};

    bq_t mq [4];
    int  mcnt [4];

    always #5 clk = ~clk;

    palindrome_detect #(.LEN(3), .CNT_W(8)) u_l3 (
        .clk(clk), .reset(reset), .valid_i(v[0]), .clear_i(c[0]), .x_i(x[0]),
        .palindrome_o(p[0]), .window_full_o(f[0]), .hit_cnt_o(hc0));
    palindrome_detect #(.LEN(4), .CNT_W(8)) u_l4 (
        .clk(clk), .reset(reset), .valid_i(v[1]), .clear_i(c[1]), .x_i(x[1]),
        .palindrome_o(p[1]), .window_full_o(f[1]), .hit_cnt_o(hc1));
    palindrome_detect #(.LEN(3), .CNT_W(2)) u_l3s (
        .clk(clk), .reset(reset), .valid_i(v[2]), .clear_i(c[2]), .x_i(x[2]),
        .palindrome_o(p[2]), .window_full_o(f[2]), .hit_cnt_o(hc2));
    palindrome_detect #(.LEN(5), .CNT_W(8)) u_l5 (
        .clk(clk), .reset(reset), .valid_i(v[3]), .clear_i(c[3]), .x_i(x[3]),
        .palindrome_o(p[3]), .window_full_o(f[3]), .hit_cnt_o(hc3));

    assign hc[0] = hc0;
    assign hc[1] = hc1;
    assign hc[2] = {6'b0, hc2};
    assign hc[3] = hc3;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Window = current bit followed by history newest-first; must read the same reversed
    function automatic bit exp_pal(int len, bq_t q, bit xb);
        bit w[$];
        if (q.size() < len - 1) return 1'b0;
        w.push_back(xb);
        for (int k = 0; k < len - 1; k++) w.push_back(q[k]);
        for (int k = 0; k < len; k++)
            if (w[k] != w[len-1-k]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset || c[i]) begin
                mq[i].delete();
                mcnt[i] = 0;
            end else if (v[i]) begin
                if (exp_pal(c_len[i], mq[i], x[i]) && mcnt[i] < c_max[i]) mcnt[i]++;
                mq[i].push_front(x[i]);
                if (mq[i].size() > c_len[i] - 1) void'(mq[i].pop_back());
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bit ep;
            ep = v[i] && !c[i] && !reset && exp_pal(c_len[i], mq[i], x[i]);
            check($sformatf("model_pal[%0d]", i), int'(p[i]), int'(ep));
            check($sformatf("model_full[%0d]", i), int'(f[i]),
                  int'(mq[i].size() == c_len[i] - 1));
            check($sformatf("model_cnt[%0d]", i), int'(hc[i]), mcnt[i]);
        end
    end

    task automatic send(input int i, input bit b, output bit pv);
        @(posedge clk); #1;
        v[i] = 1'b1; c[i] = 1'b0; x[i] = b;
        @(negedge clk);
        pv = p[i];
    endtask

    task automatic idle(input int i, input int n);
        @(posedge clk); #1;
        v[i] = 1'b0; c[i] = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic clr(input int i);
        @(posedge clk); #1;
        v[i] = 1'b0; c[i] = 1'b1;
        @(posedge clk); #1;
        c[i] = 1'b0;
    endtask

    initial begin
        bit pv;
        bit b3 [3];
        bit b5 [5];
        bit b6 [6];
        bit e6 [6];
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0; c[i] = 1'b0; x[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_full", int'(f[0]), 0);
        check("reset_cnt", int'(hc[0]), 0);

        // 1,0,1 on LEN=3
        send(0, 1'b1, pv); check("t1_b1", int'(pv), 0);
        check("t1_full_b1", int'(f[0]), 0);
        send(0, 1'b0, pv); check("t1_b2", int'(pv), 0);
        idle(0, 1);
        @(negedge clk); check("t1_full_b2", int'(f[0]), 1);
        send(0, 1'b1, pv); check("t1_b3", int'(pv), 1);
        idle(0, 1);
        @(negedge clk); check("t1_cnt", int'(hc[0]), 1);

        // Same bits with long gaps
        clr(0);
        b3 = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            send(0, b3[k], pv);
            check($sformatf("t2_b%0d", k + 1), int'(pv), (k == 2) ? 1 : 0);
            idle(0, 5);
        end
        @(negedge clk); check("t2_cnt", int'(hc[0]), 1);

        // LEN=4 even-length windows
        b6 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        e6 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            send(1, b6[k], pv);
            check($sformatf("t3_b%0d", k + 1), int'(pv), int'(e6[k]));
        end
        idle(1, 1);
        @(negedge clk); check("t3_cnt", int'(hc[1]), 2);

        // Clear overrides a valid bit that would have completed 1,0,1
        clr(0);
        send(0, 1'b1, pv);
        send(0, 1'b0, pv);
        @(posedge clk); #1;
        v[0] = 1'b1; c[0] = 1'b1; x[0] = 1'b1;
        @(negedge clk); check("t4_clr_pal", int'(p[0]), 0);
        @(posedge clk); #1;
        v[0] = 1'b0; c[0] = 1'b0;
        @(negedge clk);
        check("t4_full", int'(f[0]), 0);
        check("t4_cnt", int'(hc[0]), 0);
        b3 = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            send(0, b3[k], pv);
            check($sformatf("t4_b%0d", k + 1), int'(pv), (k == 2) ? 1 : 0);
        end
        idle(0, 1);

        // CNT_W=2 saturation on a run of ones
        for (int k = 1; k <= 8; k++) begin
            send(2, 1'b1, pv);
            check($sformatf("t5_b%0d", k), int'(pv), (k >= 3) ? 1 : 0);
            if (k == 4) check("t5_cnt_b4", int'(hc[2]), 1);
            if (k == 5) check("t5_cnt_b5", int'(hc[2]), 2);
            if (k == 6) check("t5_cnt_b6", int'(hc[2]), 3);
        end
        idle(2, 1);
        @(negedge clk); check("t5_cnt_sat", int'(hc[2]), 3);

        // LEN=5 with an asynchronous reset mid-cycle
        b3 = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) send(3, b3[k], pv);
        idle(3, 1);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_pal", int'(p[3]), 0);
        check("t6_rst_full", int'(f[3]), 0);
        check("t6_rst_cnt", int'(hc[3]), 0);
        check("t6_rst_cnt_l3", int'(hc[0]), 0);
        check("t6_rst_cnt_l4", int'(hc[1]), 0);
        @(posedge clk); #1 reset = 1'b0;
        b5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            send(3, b5[k], pv);
            check($sformatf("t6_b%0d", k + 1), int'(pv), (k == 4) ? 1 : 0);
        end
        idle(3, 1);
        @(negedge clk); check("t6_cnt", int'(hc[3]), 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palindrome_detect.md
Name: palindrome_detect

Overview:
- Streaming serial-bit palindrome detector over a sliding window of LEN bits, with the window length set by parameter.
- Each accepted bit (valid_i=1) is compared with the previous LEN-1 accepted bits. palindrome_o flags the cycle in which the LEN-bit window ending at the current bit is a palindrome.
- Adds over the fixed 3-bit detector: valid gating, synchronous clear, a fill tracker, and a saturating hit counter for status/debug readout.
- Sits on a serial input path; outputs feed control logic and status registers.

Parameters:
- LEN, 3, window length in bits; legal range 2..32.
- CNT_W, 8, width of hit counter; legal range 1..32.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  x_i carries a new bit this cycle.
- clear_i  input  1  synchronous clear of history, fill and hit count.
- x_i  input  1  serial data bit.
- palindrome_o  output  1  combinational; current window is a palindrome.
- window_full_o  output  1  registered; LEN-1 bits of history held.
- hit_cnt_o  output  CNT_W  registered count of palindrome_o pulses, saturating.

Behaviour:
- State:
  - hist_q[LEN-2:0] holds the last LEN-1 accepted bits; hist_q[0] is the newest.
  - fill_q counts from 0 to LEN-1 and saturates at LEN-1 (width clog2(LEN)).
  - hit_q[CNT_W-1:0] is the hit counter.
- Reset (async, reset=1):
  - hist_q=0, fill_q=0, hit_q=0.
  - Outputs: palindrome_o=0, window_full_o=0, hit_cnt_o=0.
  - Reset asserted mid-stream discards all history; detection restarts from an empty window.
- Window definition:
  - w[0]=x_i (current bit), w[k]=hist_q[k-1] for k=1..LEN-1.
  - pal = AND over k=0..LEN/2-1 of (w[k]==w[LEN-1-k]).
  - For odd LEN the centre bit is unconstrained.
- palindrome_o = valid_i & ~clear_i & window_full_o & pal.
  - Zero latency: it asserts in the same cycle as the completing bit.
  - It is never 1 while valid_i=0.
- window_full_o = (fill_q==LEN-1).
  - No output can assert before LEN-1 bits have been accepted since reset/clear.
  - The LEN-th accepted bit is therefore the first bit that can produce a hit.
- Accepted bit (valid_i=1, clear_i=0), on the next edge:
  - hist_q <= {hist_q[LEN-3:0], x_i}; for LEN=2, hist_q <= x_i.
  - fill_q <= min(fill_q+1, LEN-1).
  - If palindrome_o=1 and hit_q != all-ones, then hit_q <= hit_q+1.
- Idle (valid_i=0, clear_i=0): all state holds. Gaps of any length between valid bits do not affect detection.
- clear_i=1:
  - On the next edge: hist_q=0, fill_q=0, hit_q=0.
  - It overrides valid_i in the same cycle: the bit is discarded, palindrome_o=0, and the counter is not incremented.
- Overlapping windows:
  - Every accepted bit after the window is full is evaluated independently.
  - Consecutive palindromic windows give consecutive pulses, e.g. LEN=3 stream 1,1,1,1 gives hits on bits 3 and 4.
- Hit counter saturates at 2^CNT_W-1 and does not wrap. Only clear_i or reset return it to 0.
- Both palindrome parities are detected: bit patterns 0-0-0 and 1-0-1 are both palindromes.

Test Plan:
- LEN=3, reset, then valid bits 1,0,1:
  - palindrome_o=0 on bits 1 and 2, and =1 during bit 3.
  - window_full_o rises after bit 2.
  - hit_cnt_o=1 after bit 3.
- LEN=3, bits 1,0,1 with valid_i low for 5 cycles between each bit:
  - palindrome_o=1 only in the bit-3 cycle and 0 in every idle cycle.
  - hit_cnt_o=1.
- LEN=4, stream 1,0,0,1,1,0:
  - palindrome_o=1 on bit 4 (1001) and on bit 6 (0110); 0 on bit 5 (0011).
  - hit_cnt_o=2.
- LEN=3, bits 1,0, then clear_i=1 together with valid_i=1, x_i=1:
  - palindrome_o=0 in the clear cycle; window_full_o=0 and hit_cnt_o=0 afterwards.
  - Next bits 0,1,0 → hit only on the third bit.
- LEN=3, CNT_W=2, stream of 8 ones:
  - hits on bits 3..8.
  - hit_cnt_o goes 1,2,3 and then stays 3 (saturates).
- LEN=5, bits 1,0,1, then async reset pulse mid-cycle, then bits 1,0,1,0,1:
  - all outputs read 0 immediately on reset.
  - No hit until bit 5 after reset, where palindrome_o=1.
